wave_meas_04: RTL and testbench

WAVE_MEAS_04 -- requirements
Module: wave_meas_04

---
 rtl/wave_meas_04_if.sv | 27 ++
 rtl/wave_meas_04.sv | 99 +++++++++
 tb/tb_wave_meas_04.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wave_meas_04_if.sv
// Measurement bus for wave_meas_04: the waveform under test goes in and the
// period / high-time results come out, together with their status flags.
interface wave_meas_04_if;
    logic        wave_in;
    logic [31:0] period;
    logic [31:0] high_time;
    logic        meas_valid;
    logic        no_signal;

    // master: the measuring block, which produces the results
    modport master (
        input  wave_in,
        output period,
        output high_time,
        output meas_valid,
        output no_signal
    );

    // slave: the environment, which drives the wave and consumes the results
    modport slave (
        output wave_in,
        input  period,
        input  high_time,
        input  meas_valid,
        input  no_signal
    );
endinterface

// File: rtl/wave_meas_04.sv
// Square-wave period and high-time meter. It measures from one rising edge to
// the next, and declares loss of signal when no edge arrives within TIMEOUT cycles.
module wave_meas_04 #(
    parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
    input  logic           clk,
    input  logic           rst,
    wave_meas_04_if.master bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_reg;
    logic [2:0]  sync_reg;        // [0]=s1, [1]=s2, [2]=s3
    logic [31:0] cnt_reg;
    logic [31:0] hcnt_reg;
    logic [31:0] period_reg;
    logic [31:0] high_time_reg;
    logic        meas_valid_reg;
    logic        no_signal_reg;

    logic        s2;
    logic        s3;
    logic        rise;
    logic        cnt_at_limit;

    assign s2           = sync_reg[1];
    assign s3           = sync_reg[2];
    assign rise         = s2 & ~s3;
    assign cnt_at_limit = (cnt_reg == (TIMEOUT - 32'd1));

    // Two stages resynchronise the asynchronous input. The third stage gives
    // the previous value for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[1:0], bus.wave_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            hcnt_reg       <= '0;
            period_reg     <= '0;
            high_time_reg  <= '0;
            meas_valid_reg <= 1'b0;
            no_signal_reg  <= 1'b0;
        end else begin
            meas_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // The first edge only opens a measurement window.
                    if (rise) begin
                        state_reg <= RUN;
                        cnt_reg   <= '0;
                        hcnt_reg  <= 32'd1;
                    end
                end
                RUN: begin
                    // An edge on the last allowed cycle still counts as a
                    // valid measurement, so rise is tested before timeout.
                    if (rise) begin
                        period_reg     <= cnt_reg + 32'd1;
                        high_time_reg  <= hcnt_reg;
                        meas_valid_reg <= 1'b1;
                        no_signal_reg  <= 1'b0;
                        cnt_reg        <= '0;
                        hcnt_reg       <= 32'd1;
                    end else if (cnt_at_limit) begin
                        state_reg     <= IDLE;
                        no_signal_reg <= 1'b1;
                        period_reg    <= '0;
                        high_time_reg <= '0;
                        cnt_reg       <= '0;
                        hcnt_reg      <= '0;
                    end else begin
                        cnt_reg  <= cnt_reg + 32'd1;
                        hcnt_reg <= hcnt_reg + {31'd0, s2};
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.period     = period_reg;
    assign bus.high_time  = high_time_reg;
    assign bus.meas_valid = meas_valid_reg;
    assign bus.no_signal  = no_signal_reg;

endmodule

// File: tb/tb_wave_meas_04.sv
// Randomised and directed bench for wave_meas_04. A per-edge reference model
// predicts the outputs from the recorded input history.
module tb_wave_meas_04;

    localparam int TO   = 100;
    localparam int MAXE = 30000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    wave_meas_04_if bus ();

    wave_meas_04 #(.TIMEOUT(32'd100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int d     = 0;

    // Input value seen at each clock edge, with zeros where reset cleared the synchroniser.
    bit          xs [0:MAXE-1];
    bit          armed     = 1'b0;
    int          last_rise = 0;
    logic [31:0] e_period  = '0;
    logic [31:0] e_high    = '0;
    logic        e_valid   = 1'b0;
    logic        e_nosig   = 1'b0;

    int          strobes           = 0;
    int          last_strobe_edge  = 0;
    int          prev_strobe_edge  = 0;
    int          nosig_edge        = 0;
    logic [31:0] seen_period       = '0;
    logic [31:0] seen_high         = '0;
    bit          nosig_seen        = 1'b0;
    bit          prev_nosig        = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, d, got, exp);
        end
    endtask

    // Rules model: a rise is a 0->1 step in the input seen 2 edges earlier.
    // Period is the distance between rises. High time is the number of high
    // samples between the rises.
    task automatic model_step(input bit w, input bit r);
        bit rise;
        int hsum;
        xs[d] = w;
        if (r) begin
            xs[d] = 1'b0;
            if (d >= 1) xs[d-1] = 1'b0;
            if (d >= 2) xs[d-2] = 1'b0;
            armed    = 1'b0;
            e_period = '0;
            e_high   = '0;
            e_valid  = 1'b0;
            e_nosig  = 1'b0;
            return;
        end
        rise    = (d >= 3) && xs[d-2] && !xs[d-3];
        e_valid = 1'b0;
        if (!armed) begin
            if (rise) begin
                armed     = 1'b1;
                last_rise = d;
            end
        end else if (rise) begin
            hsum = 0;
            for (int j = last_rise; j < d; j++) hsum += int'(xs[j-2]);
            e_period  = 32'(d - last_rise);
            e_high    = 32'(hsum);
            e_valid   = 1'b1;
            e_nosig   = 1'b0;
            last_rise = d;
        end else if (d - last_rise == TO) begin
            armed    = 1'b0;
            e_nosig  = 1'b1;
            e_period = '0;
            e_high   = '0;
        end
    endtask

    task automatic cycle(input bit w, input bit r);
        bus.wave_in = w;
        rst         = r;
        @(posedge clk);
        d++;
        if (d >= MAXE) begin
            $display("FAIL edge_budget: got %0d edges, limit %0d", d, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        model_step(w, r);
        @(negedge clk);
        chk("meas_valid", {31'd0, bus.meas_valid}, {31'd0, e_valid});
        chk("no_signal",  {31'd0, bus.no_signal},  {31'd0, e_nosig});
        chk("period",     bus.period,    e_period);
        chk("high_time",  bus.high_time, e_high);
        if (bus.meas_valid === 1'b1) begin
            strobes++;
            prev_strobe_edge = last_strobe_edge;
            last_strobe_edge = d;
            seen_period      = bus.period;
            seen_high        = bus.high_time;
        end
        if (bus.no_signal === 1'b1 && !prev_nosig) nosig_edge = d;
        prev_nosig = (bus.no_signal === 1'b1);
        if (bus.no_signal === 1'b1) nosig_seen = 1'b1;
    endtask

    task automatic wave(input int lo, input int hi, input int n);
        repeat (n) begin
            repeat (lo) cycle(1'b0, 1'b0);
            repeat (hi) cycle(1'b1, 1'b0);
        end
    endtask

    task automatic clear_obs();
        strobes    = 0;
        nosig_seen = 1'b0;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        clear_obs();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wave_in = 1'b0;
        do_reset();
        chk("rst_period",     bus.period, 32'd0);
        chk("rst_high_time",  bus.high_time, 32'd0);
        chk("rst_meas_valid", {31'd0, bus.meas_valid}, 32'd0);
        chk("rst_no_signal",  {31'd0, bus.no_signal}, 32'd0);

        // 5 low / 5 high
        wave(5, 5, 6);
        repeat (4) cycle(1'b0, 1'b0);
        chk("p10_strobes", strobes, 32'd5);
        chk("p10_period",  seen_period, 32'd10);
        chk("p10_high",    seen_high, 32'd5);
        chk("p10_spacing", last_strobe_edge - prev_strobe_edge, 32'd10);

        // 3 low / 4 high
        do_reset();
        wave(3, 4, 5);
        repeat (4) cycle(1'b0, 1'b0);
        chk("p7_strobes", strobes, 32'd4);
        chk("p7_period",  seen_period, 32'd7);
        chk("p7_high",    seen_high, 32'd4);

        // fastest measurable wave
        do_reset();
        wave(1, 1, 8);
        repeat (3) cycle(1'b0, 1'b0);
        chk("p2_strobes", strobes, 32'd7);
        chk("p2_period",  seen_period, 32'd2);
        chk("p2_high",    seen_high, 32'd1);
        chk("p2_spacing", last_strobe_edge - prev_strobe_edge, 32'd2);

        // loss of signal, then recovery
        do_reset();
        wave(5, 5, 3);
        repeat (110) cycle(1'b0, 1'b0);
        chk("to_strobes",   strobes, 32'd2);
        chk("to_no_signal", {31'd0, bus.no_signal}, 32'd1);
        chk("to_period",    bus.period, 32'd0);
        chk("to_high",      bus.high_time, 32'd0);
        chk("to_delay",     nosig_edge - last_strobe_edge, 32'd100);
        clear_obs();
        wave(5, 5, 3);
        repeat (4) cycle(1'b0, 1'b0);
        chk("resume_strobes",   strobes, 32'd2);
        chk("resume_period",    seen_period, 32'd10);
        chk("resume_no_signal", {31'd0, bus.no_signal}, 32'd0);

        // rise exactly on the last allowed cycle
        do_reset();
        repeat (5)  cycle(1'b0, 1'b0);
        repeat (5)  cycle(1'b1, 1'b0);
        repeat (95) cycle(1'b0, 1'b0);
        repeat (5)  cycle(1'b1, 1'b0);
        repeat (4)  cycle(1'b0, 1'b0);
        chk("edge100_strobes", strobes, 32'd1);
        chk("edge100_period",  seen_period, 32'd100);
        chk("edge100_high",    seen_high, 32'd5);
        chk("edge100_nosig",   {31'd0, nosig_seen}, 32'd0);

        // one cycle too late: timeout wins
        do_reset();
        repeat (5)  cycle(1'b0, 1'b0);
        repeat (5)  cycle(1'b1, 1'b0);
        repeat (96) cycle(1'b0, 1'b0);
        repeat (5)  cycle(1'b1, 1'b0);
        repeat (4)  cycle(1'b0, 1'b0);
        chk("edge101_strobes", strobes, 32'd0);
        chk("edge101_nosig",   {31'd0, nosig_seen}, 32'd1);

        // reset in the middle of a period
        do_reset();
        wave(5, 5, 3);
        repeat (2) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        chk("midrst_period", bus.period, 32'd0);
        chk("midrst_high",   bus.high_time, 32'd0);
        chk("midrst_valid",  {31'd0, bus.meas_valid}, 32'd0);
        chk("midrst_nosig",  {31'd0, bus.no_signal}, 32'd0);
        clear_obs();
        repeat (2) cycle(1'b0, 1'b0);
        wave(5, 5, 3);
        repeat (4) cycle(1'b0, 1'b0);
        chk("midrst_strobes",     strobes, 32'd2);
        chk("midrst_post_period", seen_period, 32'd10);
        chk("midrst_post_high",   seen_high, 32'd5);

        // random waves, occasional long gaps and stray resets
        do_reset();
        for (int it = 0; it < 250; it++) begin
            int lo;
            int hi;
            lo = int'($urandom_range(1, 12));
            hi = int'($urandom_range(1, 12));
            if ($urandom_range(0, 29) == 0) lo = int'($urandom_range(90, 130));
            repeat (lo) cycle(1'b0, $urandom_range(0, 199) == 0);
            repeat (hi) cycle(1'b1, $urandom_range(0, 299) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
